pipe_hazard_ctrl: RTL and testbench

Parametrised stall/flush controller for an N-stage in-order pipeline. It generalises the fixed 5-stage stall unit to configurable depth and memory-stage position, and adds two things the fixed unit lacks: multi-cycle load-use interlock and I-fetch cancellation on redirect. It also provides saturating stall and redirect performance counters. It sits beside the pipeline registers and drives their stall/flush inputs and the PC stall.

---
 rtl/pipe_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for an N-stage in-order pipeline: D-miss, redirect,
// multi-cycle load-use interlock and I-miss handling, plus saturating perf counters.
module pipe_hazard_ctrl #(
  parameter int STAGES    = 5,
  parameter int MEM_STAGE = 3,
  parameter int REG_W     = 5,
  parameter int CNT_W     = 16
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                i_ICache_Miss,
  input  logic                i_DCache_Miss,
  input  logic                i_Redirect,
  input  logic                i_ID_Need_Rs1,
  input  logic                i_ID_Need_Rs2,
  input  logic [REG_W-1:0]    i_ID_Rs1,
  input  logic [REG_W-1:0]    i_ID_Rs2,
  input  logic                i_EX_Read_MEM,
  input  logic                i_EX_R_WE,
  input  logic [REG_W-1:0]    i_EX_Rdst,
  input  logic                i_Clr_Cnt,
  output logic                o_PC_Stall,
  output logic [STAGES-2:0]   o_Stall,
  output logic [STAGES-2:0]   o_Flush,
  output logic                o_IFetch_Cancel,
  output logic                o_LdUse_Busy,
  output logic [CNT_W-1:0]    o_Stall_Cnt,
  output logic [CNT_W-1:0]    o_Redirect_Cnt
);

  localparam int BW = $clog2(STAGES);
  localparam logic [STAGES-2:0] ONE      = 1;
  localparam logic [STAGES-2:0] DM_STALL = {{(STAGES-1-MEM_STAGE){1'b0}}, {MEM_STAGE{1'b1}}};
  localparam logic [STAGES-2:0] DM_FLUSH = ONE << MEM_STAGE;

  typedef enum logic {RUN, LDUSE} state_t;

  state_t        state, nxt_state;
  logic [BW-1:0] bub, nxt_bub;
  logic          hz, act_dm, act_rd, act_lu, act_im;

  always_comb begin
    hz = i_EX_Read_MEM & i_EX_R_WE & (i_EX_Rdst != '0) &
         ((i_ID_Need_Rs1 & (i_ID_Rs1 == i_EX_Rdst)) |
          (i_ID_Need_Rs2 & (i_ID_Rs2 == i_EX_Rdst)));
    act_dm = i_DCache_Miss;
    act_rd = !i_DCache_Miss & i_Redirect;
    act_lu = !i_DCache_Miss & !i_Redirect & (((state == RUN) & hz) | (state == LDUSE));
    act_im = !i_DCache_Miss & !i_Redirect & !act_lu & i_ICache_Miss;
  end

  // Outputs are forced to the bubble-everything pattern while reset is held.
  always_comb begin
    o_PC_Stall      = 1'b0;
    o_Stall         = '0;
    o_Flush         = '0;
    o_IFetch_Cancel = 1'b0;
    o_LdUse_Busy    = Rst & (state == LDUSE);
    if (!Rst) begin
      o_Flush = '1;
    end else if (act_dm) begin
      o_PC_Stall = 1'b1;
      o_Stall    = DM_STALL;
      o_Flush    = DM_FLUSH;
    end else if (act_rd) begin
      o_Flush         = ONE | (ONE << 1);
      o_IFetch_Cancel = i_ICache_Miss;
    end else if (act_lu) begin
      o_PC_Stall = 1'b1;
      o_Stall    = ONE;
      o_Flush    = ONE << 1;
    end else if (act_im) begin
      o_PC_Stall = 1'b1;
      o_Flush    = ONE;
    end
  end

  // First bubble comes from RUN; LDUSE supplies the remaining MEM_STAGE-3.
  always_comb begin
    nxt_state = state;
    nxt_bub   = bub;
    case (state)
      RUN: begin
        if (act_lu && MEM_STAGE > 3) begin
          nxt_state = LDUSE;
          nxt_bub   = BW'(MEM_STAGE - 3);
        end
      end
      LDUSE: begin
        if (act_rd) begin
          nxt_state = RUN;
          nxt_bub   = '0;
        end else if (act_lu) begin
          if (bub <= BW'(1)) begin
            nxt_state = RUN;
            nxt_bub   = '0;
          end else begin
            nxt_bub = bub - BW'(1);
          end
        end
      end
      default: begin
        nxt_state = RUN;
        nxt_bub   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= RUN;
      bub   <= '0;
    end else begin
      state <= nxt_state;
      bub   <= nxt_bub;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      o_Stall_Cnt    <= '0;
      o_Redirect_Cnt <= '0;
    end else if (i_Clr_Cnt) begin
      o_Stall_Cnt    <= '0;
      o_Redirect_Cnt <= '0;
    end else begin
      if (o_PC_Stall && o_Stall_Cnt != '1)
        o_Stall_Cnt <= o_Stall_Cnt + CNT_W'(1);
      if (act_rd && o_Redirect_Cnt != '1)
        o_Redirect_Cnt <= o_Redirect_Cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: default config, a deeper memory stage config and a narrow-counter config.
module tb_pipe_hazard_ctrl;

  logic       Clk, Rst;
  logic       imiss, dmiss, redir, nrs1, nrs2, rdmem, rwe, clr;
  logic [4:0] rs1, rs2, rdst;

  logic        pc0, ca0, bz0;
  logic [3:0]  st0, fl0;
  logic [15:0] sc0, rc0;
  logic        pc1, ca1, bz1;
  logic [4:0]  st1, fl1;
  logic [15:0] sc1, rc1;
  logic        pc2, ca2, bz2;
  logic [3:0]  st2, fl2;
  logic [3:0]  sc2, rc2;

  pipe_hazard_ctrl u0 (
    .Clk(Clk), .Rst(Rst), .i_ICache_Miss(imiss), .i_DCache_Miss(dmiss), .i_Redirect(redir),
    .i_ID_Need_Rs1(nrs1), .i_ID_Need_Rs2(nrs2), .i_ID_Rs1(rs1), .i_ID_Rs2(rs2),
    .i_EX_Read_MEM(rdmem), .i_EX_R_WE(rwe), .i_EX_Rdst(rdst), .i_Clr_Cnt(clr),
    .o_PC_Stall(pc0), .o_Stall(st0), .o_Flush(fl0), .o_IFetch_Cancel(ca0),
    .o_LdUse_Busy(bz0), .o_Stall_Cnt(sc0), .o_Redirect_Cnt(rc0));

  pipe_hazard_ctrl #(.STAGES(6), .MEM_STAGE(4)) u1 (
    .Clk(Clk), .Rst(Rst), .i_ICache_Miss(imiss), .i_DCache_Miss(dmiss), .i_Redirect(redir),
    .i_ID_Need_Rs1(nrs1), .i_ID_Need_Rs2(nrs2), .i_ID_Rs1(rs1), .i_ID_Rs2(rs2),
    .i_EX_Read_MEM(rdmem), .i_EX_R_WE(rwe), .i_EX_Rdst(rdst), .i_Clr_Cnt(clr),
    .o_PC_Stall(pc1), .o_Stall(st1), .o_Flush(fl1), .o_IFetch_Cancel(ca1),
    .o_LdUse_Busy(bz1), .o_Stall_Cnt(sc1), .o_Redirect_Cnt(rc1));

  pipe_hazard_ctrl #(.CNT_W(4)) u2 (
    .Clk(Clk), .Rst(Rst), .i_ICache_Miss(imiss), .i_DCache_Miss(dmiss), .i_Redirect(redir),
    .i_ID_Need_Rs1(nrs1), .i_ID_Need_Rs2(nrs2), .i_ID_Rs1(rs1), .i_ID_Rs2(rs2),
    .i_EX_Read_MEM(rdmem), .i_EX_R_WE(rwe), .i_EX_Rdst(rdst), .i_Clr_Cnt(clr),
    .o_PC_Stall(pc2), .o_Stall(st2), .o_Flush(fl2), .o_IFetch_Cancel(ca2),
    .o_LdUse_Busy(bz2), .o_Stall_Cnt(sc2), .o_Redirect_Cnt(rc2));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic idle();
    imiss = 0; dmiss = 0; redir = 0; nrs1 = 0; nrs2 = 0;
    rdmem = 0; rwe = 0; clr = 0; rs1 = 0; rs2 = 0; rdst = 0;
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  task automatic do_reset();
    idle();
    Rst = 0;
    tick();
    Rst = 1;
    #1;
  endtask

  // ID reads rs1=5, EX is a load writing r5
  task automatic ldu();
    nrs1 = 1; rs1 = 5; rdmem = 1; rwe = 1; rdst = 5;
  endtask

  typedef struct {
    string      nm;
    logic       dm, im, rd, n1, n2;
    logic [4:0] r1, r2;
    logic       ld, we;
    logic [4:0] dst;
    logic       e_pc;
    logic [3:0] e_st, e_fl;
    logic       e_ca;
  } vec_t;

  vec_t vt[14];

  initial begin
    //           nm          dm im rd n1 n2 r1 r2 ld we dst  pc st       fl       ca
    vt[0]  = '{"idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0000, 0};
    vt[1]  = '{"lu_rs1",     0, 0, 0, 1, 0, 5, 0, 1, 1, 5,   1, 4'b0001, 4'b0010, 0};
    vt[2]  = '{"lu_rd0",     0, 0, 0, 1, 0, 0, 0, 1, 1, 0,   0, 4'b0000, 4'b0000, 0};
    vt[3]  = '{"lu_rs2",     0, 0, 0, 0, 1, 0, 7, 1, 1, 7,   1, 4'b0001, 4'b0010, 0};
    vt[4]  = '{"no_need",    0, 0, 0, 0, 0, 5, 5, 1, 1, 5,   0, 4'b0000, 4'b0000, 0};
    vt[5]  = '{"not_load",   0, 0, 0, 1, 0, 5, 0, 0, 1, 5,   0, 4'b0000, 4'b0000, 0};
    vt[6]  = '{"no_we",      0, 0, 0, 1, 0, 5, 0, 1, 0, 5,   0, 4'b0000, 4'b0000, 0};
    vt[7]  = '{"dmiss",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0111, 4'b1000, 0};
    vt[8]  = '{"redir",      0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0011, 0};
    vt[9]  = '{"im_redir",   0, 1, 1, 0, 0, 0, 0, 0, 0, 0,   0, 4'b0000, 4'b0011, 1};
    vt[10] = '{"imiss",      0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 4'b0000, 4'b0001, 0};
    vt[11] = '{"dm_all",     1, 1, 1, 1, 0, 5, 0, 1, 1, 5,   1, 4'b0111, 4'b1000, 0};
    vt[12] = '{"lu_im",      0, 1, 0, 1, 0, 5, 0, 1, 1, 5,   1, 4'b0001, 4'b0010, 0};
    vt[13] = '{"lu_redir",   0, 0, 1, 1, 0, 5, 0, 1, 1, 5,   0, 4'b0000, 4'b0011, 0};

    // reset state
    idle();
    Rst = 0;
    #2;
    chk("rst_flush", 32'(fl0), 32'hF);
    chk("rst_flush6", 32'(fl1), 32'h1F);
    chk("rst_stall", 32'(st0), 0);
    chk("rst_pc", 32'(pc0), 0);
    chk("rst_ca", 32'(ca0), 0);
    chk("rst_scnt", 32'(sc0), 0);
    chk("rst_rcnt", 32'(rc0), 0);
    tick();
    Rst = 1;
    #1;
    chk("rel_flush", 32'(fl0), 0);
    chk("rel_pc", 32'(pc0), 0);
    chk("rel_busy", 32'(bz0), 0);

    // single-cycle vectors on the default config
    for (int i = 0; i < 14; i++) begin
      dmiss = vt[i].dm; imiss = vt[i].im; redir = vt[i].rd;
      nrs1 = vt[i].n1; nrs2 = vt[i].n2; rs1 = vt[i].r1; rs2 = vt[i].r2;
      rdmem = vt[i].ld; rwe = vt[i].we; rdst = vt[i].dst;
      #1;
      chk({vt[i].nm, "_pc"}, 32'(pc0), 32'(vt[i].e_pc));
      chk({vt[i].nm, "_st"}, 32'(st0), 32'(vt[i].e_st));
      chk({vt[i].nm, "_fl"}, 32'(fl0), 32'(vt[i].e_fl));
      chk({vt[i].nm, "_ca"}, 32'(ca0), 32'(vt[i].e_ca));
      tick();
      idle();
    end

    // deep config: two bubbles
    do_reset();
    ldu();
    #1;
    chk("d1_pc", 32'(pc1), 1);
    chk("d1_st", 32'(st1), 32'h01);
    chk("d1_fl", 32'(fl1), 32'h02);
    chk("d1_bz", 32'(bz1), 0);
    tick();
    idle();
    #1;
    chk("d2_pc", 32'(pc1), 1);
    chk("d2_st", 32'(st1), 32'h01);
    chk("d2_fl", 32'(fl1), 32'h02);
    chk("d2_bz", 32'(bz1), 1);
    tick();
    chk("d3_pc", 32'(pc1), 0);
    chk("d3_bz", 32'(bz1), 0);
    chk("d3_fl", 32'(fl1), 0);

    // deep config: D-miss freezes LDUSE
    do_reset();
    ldu();
    tick();
    idle();
    dmiss = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("fz_bz", 32'(bz1), 1);
      chk("fz_st", 32'(st1), 32'h0F);
      chk("fz_fl", 32'(fl1), 32'h10);
      tick();
    end
    dmiss = 0;
    #1;
    chk("fz_last_bz", 32'(bz1), 1);
    chk("fz_last_st", 32'(st1), 32'h01);
    chk("fz_last_fl", 32'(fl1), 32'h02);
    tick();
    chk("fz_done_pc", 32'(pc1), 0);
    chk("fz_done_bz", 32'(bz1), 0);

    // deep config: redirect aborts LDUSE
    do_reset();
    ldu();
    tick();
    idle();
    redir = 1;
    #1;
    chk("ab_fl", 32'(fl1), 32'h03);
    chk("ab_pc", 32'(pc1), 0);
    tick();
    redir = 0;
    #1;
    chk("ab_bz", 32'(bz1), 0);
    chk("ab_pc2", 32'(pc1), 0);

    // D-miss with redirect held: redirect deferred, counted once
    do_reset();
    dmiss = 1; redir = 1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("dr_st", 32'(st0), 32'h7);
      chk("dr_fl", 32'(fl0), 32'h8);
      chk("dr_rcnt", 32'(rc0), 0);
      tick();
    end
    dmiss = 0;
    #1;
    chk("dr_fl2", 32'(fl0), 32'h3);
    chk("dr_pc2", 32'(pc0), 0);
    tick();
    redir = 0;
    #1;
    chk("dr_rcnt1", 32'(rc0), 1);
    chk("dr_scnt3", 32'(sc0), 3);

    // counter saturation and clear
    do_reset();
    imiss = 1;
    repeat (20) tick();
    chk("sat4", 32'(sc2), 15);
    chk("wide20", 32'(sc0), 20);
    chk("sat_rcnt", 32'(rc2), 0);
    clr = 1;
    tick();
    clr = 0;
    chk("clr", 32'(sc2), 0);
    tick();
    chk("clr_inc", 32'(sc2), 1);
    idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
